// File: rtl/pc_fetch_gen.sv
// Program counter and fetch-request generator: issues FETCH_N-instruction aligned
// block requests, holds them stable until accepted and buffers redirects meanwhile.
module pc_fetch_gen #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'hbfc0_0000,
  parameter logic [ADDR_W-1:0]  EXC_VEC  = 32'hbfc0_0380,
  parameter int                 FETCH_N  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exception,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_adel
);

  localparam logic [ADDR_W-1:0] BLK      = ADDR_W'(4 * FETCH_N);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~(BLK - ADDR_W'(1));

  // Encoding order is the priority order, so a plain >= compares classes.
  typedef enum logic [1:0] {
    CLS_BR   = 2'd0,
    CLS_ERET = 2'd1,
    CLS_EXC  = 2'd2
  } redir_cls_e;

  logic [ADDR_W-1:0] r_pc;
  logic              r_hold;
  logic              r_pend_v;
  redir_cls_e        r_pend_cls;
  logic [ADDR_W-1:0] r_pend_tgt;

  logic              w_redir_v;
  redir_cls_e        w_redir_cls;
  logic [ADDR_W-1:0] w_redir_tgt;
  logic              w_pend_take;
  logic              w_adv;
  logic [ADDR_W-1:0] w_blk_base;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_redir_v   = 1'b0;
    w_redir_cls = CLS_BR;
    w_redir_tgt = br_target;
    if (exception) begin
      w_redir_v   = 1'b1;
      w_redir_cls = CLS_EXC;
      w_redir_tgt = EXC_VEC;
    end else if (eret) begin
      w_redir_v   = 1'b1;
      w_redir_cls = CLS_ERET;
      w_redir_tgt = epc;
    end else if (br_take) begin
      w_redir_v   = 1'b1;
      w_redir_cls = CLS_BR;
      w_redir_tgt = br_target;
    end
  end

  // A held request keeps inst_req high regardless of stall, redirects or reset.
  assign pc_adel     = (r_pc[1:0] != 2'b00);
  assign inst_req    = r_hold | (~stall & ~pc_adel & ~reset);
  assign w_blk_base  = r_pc & BLK_MASK;
  assign inst_addr   = w_blk_base;
  assign pc          = r_pc;
  assign w_adv       = ~inst_req | inst_addr_ok;
  assign w_pend_take = w_redir_v & (~r_pend_v | (w_redir_cls >= r_pend_cls));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_hold     <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_cls <= CLS_BR;
      r_pend_tgt <= '0;
    end else if (w_adv) begin
      // Either no request is up or it was accepted: nothing left to hold.
      r_hold   <= 1'b0;
      r_pend_v <= 1'b0;
      if (w_redir_v) begin
        r_pc <= w_redir_tgt;
      end else if (r_pend_v) begin
        r_pc <= r_pend_tgt;
      end else if (inst_req && inst_addr_ok) begin
        r_pc <= w_blk_base + BLK;
      end
    end else begin
      // Request is up and not accepted; pc stays put, redirects are parked.
      r_hold <= 1'b1;
      if (w_pend_take) begin
        r_pend_v   <= 1'b1;
        r_pend_cls <= w_redir_cls;
        r_pend_tgt <= w_redir_tgt;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: one FETCH_N=1 and one FETCH_N=2 instance
// share stimulus; expected values are hand-computed constants.
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        reset, stall, exception, eret, br_take, inst_addr_ok;
  logic [31:0] epc, br_target;

  logic        req1, adel1, req2, adel2;
  logic [31:0] addr1, pc1, addr2, pc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch_gen #(.FETCH_N(1)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .exception(exception), .eret(eret),
    .epc(epc), .br_take(br_take), .br_target(br_target), .inst_req(req1),
    .inst_addr(addr1), .inst_addr_ok(inst_addr_ok), .pc(pc1), .pc_adel(adel1)
  );

  pc_fetch_gen #(.FETCH_N(2)) u_dut2 (
    .clk(clk), .reset(reset), .stall(stall), .exception(exception), .eret(eret),
    .epc(epc), .br_take(br_take), .br_target(br_target), .inst_req(req2),
    .inst_addr(addr2), .inst_addr_ok(inst_addr_ok), .pc(pc2), .pc_adel(adel2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and return 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; exception = 1'b0; eret = 1'b0; br_take = 1'b0;
    inst_addr_ok = 1'b1; epc = '0; br_target = '0;

    // Reset state
    tick();
    check("rst_pc", pc1, 32'hbfc0_0000);
    check("rst_req", {31'b0, req1}, 32'd0);
    check("rst_adel", {31'b0, adel1}, 32'd0);

    // Sequential fetch, FETCH_N=1
    reset = 1'b0; settle();
    check("seq_req0", {31'b0, req1}, 32'd1);
    check("seq_addr0", addr1, 32'hbfc0_0000);
    tick();
    check("seq_addr1", addr1, 32'hbfc0_0004);
    tick();
    check("seq_addr2", addr1, 32'hbfc0_0008);
    check("seq_adel", {31'b0, adel1}, 32'd0);

    // Branch to a mid-block target
    br_take = 1'b1; br_target = 32'h8000_1004;
    tick();
    br_take = 1'b0; settle();
    check("br_pc_n2", pc2, 32'h8000_1004);
    check("br_addr_n2", addr2, 32'h8000_1000);
    check("br_addr_n1", addr1, 32'h8000_1004);
    tick();
    check("br_next_n2", addr2, 32'h8000_1008);
    check("br_next_n1", addr1, 32'h8000_1008);

    // Request waits three cycles; branch (with stall) arrives in the second
    inst_addr_ok = 1'b0; settle();
    check("hold_req1", {31'b0, req1}, 32'd1);
    check("hold_addr1", addr1, 32'h8000_1008);
    tick();
    br_take = 1'b1; br_target = 32'h8000_2000; stall = 1'b1; settle();
    check("hold_req2", {31'b0, req1}, 32'd1);
    check("hold_addr2", addr1, 32'h8000_1008);
    tick();
    br_take = 1'b0; stall = 1'b0; settle();
    check("hold_addr3", addr1, 32'h8000_1008);
    tick();
    inst_addr_ok = 1'b1; settle();
    check("hold_addr4", addr1, 32'h8000_1008);
    tick();
    check("pend_br_pc", pc1, 32'h8000_2000);
    check("pend_br_addr", addr1, 32'h8000_2000);

    // Pending exception survives a later eret and branch
    inst_addr_ok = 1'b0;
    tick();
    exception = 1'b1;
    tick();
    exception = 1'b0; eret = 1'b1; epc = 32'h8000_4000;
    tick();
    eret = 1'b0; br_take = 1'b1; br_target = 32'h8000_3000;
    tick();
    br_take = 1'b0; settle();
    check("pend_wait_addr", addr1, 32'h8000_2000);
    inst_addr_ok = 1'b1;
    tick();
    check("pend_exc_pc", pc1, 32'hbfc0_0380);
    tick();
    check("exc_next_pc", pc1, 32'hbfc0_0384);

    // Simultaneous exception and eret with adv=1
    exception = 1'b1; eret = 1'b1; epc = 32'h8000_5000;
    tick();
    exception = 1'b0; eret = 1'b0; settle();
    check("exc_eret_pc", pc1, 32'hbfc0_0380);

    // Misaligned eret target parks pc with pc_adel and no request
    eret = 1'b1; epc = 32'h8000_0002;
    tick();
    eret = 1'b0; settle();
    check("adel_pc", pc1, 32'h8000_0002);
    check("adel_flag", {31'b0, adel1}, 32'd1);
    check("adel_req", {31'b0, req1}, 32'd0);
    check("adel_flag_n2", {31'b0, adel2}, 32'd1);
    tick();
    check("adel_pc_hold", pc1, 32'h8000_0002);
    check("adel_req_hold", {31'b0, req1}, 32'd0);
    exception = 1'b1;
    tick();
    exception = 1'b0; settle();
    check("adel_exit_pc", pc1, 32'hbfc0_0380);
    check("adel_exit_req", {31'b0, req1}, 32'd1);
    check("adel_exit_flag", {31'b0, adel1}, 32'd0);

    // Wrap at the top of the address space
    br_take = 1'b1; br_target = 32'hffff_fffc;
    tick();
    br_take = 1'b0; settle();
    check("wrap_pre_pc", pc1, 32'hffff_fffc);
    check("wrap_pre_addr_n2", addr2, 32'hffff_fff8);
    tick();
    check("wrap_pc", pc1, 32'h0000_0000);
    check("wrap_pc_n2", pc2, 32'h0000_0000);

    // Stall with nothing held: no request, pc frozen
    stall = 1'b1; settle();
    check("stall_req", {31'b0, req1}, 32'd0);
    tick();
    check("stall_pc", pc1, 32'h0000_0000);

    // Stall with a held request: request stays up until accepted
    stall = 1'b0; inst_addr_ok = 1'b0;
    tick();
    stall = 1'b1; settle();
    check("stall_hold_req", {31'b0, req1}, 32'd1);
    check("stall_hold_addr", addr1, 32'h0000_0000);
    tick();
    check("stall_hold_req2", {31'b0, req1}, 32'd1);
    inst_addr_ok = 1'b1;
    tick();
    check("stall_acc_pc", pc1, 32'h0000_0004);
    check("stall_acc_req", {31'b0, req1}, 32'd0);

    // Reset mid-handshake discards hold and the parked eret
    stall = 1'b0; inst_addr_ok = 1'b0;
    tick();
    eret = 1'b1; epc = 32'h8000_6000;
    tick();
    eret = 1'b0; reset = 1'b1;
    tick();
    check("rst_mid_pc", pc1, 32'hbfc0_0000);
    check("rst_mid_req", {31'b0, req1}, 32'd0);
    reset = 1'b0; inst_addr_ok = 1'b1; settle();
    check("rst_mid_req1", {31'b0, req1}, 32'd1);
    tick();
    check("rst_mid_next", pc1, 32'hbfc0_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised program-counter and fetch-request generator for the instruction fetch stage. It replaces the single-instruction PC register with one that:
- fetches FETCH_N-instruction aligned blocks;
- drives a request/address-accept handshake to the instruction SRAM-like port;
- buffers redirects (exception, eret, branch) that arrive while a request is waiting for acceptance;
- flags misaligned redirect targets instead of fetching them.

It sits between the branch/exception resolution logic and the instruction memory interface.

## Interface
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'hbfc0_0000, PC value loaded by reset.
- EXC_VEC, 32'hbfc0_0380, exception entry address.
- FETCH_N, 1, instructions per fetch block; legal values 1, 2, 4. Block size B = 4*FETCH_N bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  fetch stage cannot take a new block; blocks new requests only.
- exception  in  1  pulse: redirect to EXC_VEC.
- eret  in  1  pulse: redirect to epc.
- epc  in  ADDR_W  eret target.
- br_take  in  1  pulse: redirect to br_target.
- br_target  in  ADDR_W  branch target.
- inst_req  out  1  fetch request.
- inst_addr  out  ADDR_W  pc aligned down to B.
- inst_addr_ok  in  1  memory accepts request this cycle.
- pc  out  ADDR_W  exact current fetch PC; first valid slot = pc[log2(B)-1:2].
- pc_adel  out  1  pc[1:0] != 0 (address-error on fetch).

## Operation
Redirect priority, same cycle: exception > eret > br_take.
- Priority class: exception=2, eret=1, branch=0.
- Only the winner is used.

State registers: pc, hold (request outstanding and not yet accepted), pend_v, pend_cls, pend_tgt.

Request generation:
- inst_req = hold | (!stall & !pc_adel & !reset).
- inst_addr = pc & ~(B-1).
- Once inst_req is 1 with inst_addr_ok=0, inst_req and inst_addr hold stable until accepted, regardless of stall or redirects.

Advance condition: adv = !inst_req | inst_addr_ok.

Next PC on an adv edge, first match wins:
1. Redirect present this cycle: winner target.
2. pend_v: pend_tgt; pend_v clears.
3. Request accepted: (pc & ~(B-1)) + B, modulo 2^ADDR_W (wraps to 0).
4. Otherwise: pc holds.

Non-adv edge (request waiting, not accepted):
- pc holds.
- A redirect is captured into pend if !pend_v or its class >= pend_cls; otherwise it is dropped.
- hold <= inst_req & !inst_addr_ok.

Misaligned target:
- The target is still loaded into pc; pc_adel=1 and no request is issued.
- pc waits for a later redirect. The downstream pipeline raises the exception from pc_adel.

## Timing
- Reset: pc=RESET_PC, hold=0, pend_v=0, pend_cls=0, pend_tgt=0, inst_req=0, pc_adel=0.
- First cycle after reset deasserts with stall=0: inst_req=1, inst_addr=RESET_PC & ~(B-1).
- Redirect in cycle t with adv=1: pc = target in t+1, request issued in t+1 if stall=0 and aligned.
- Redirect in cycle t with request waiting: old request continues. After acceptance in cycle u, pc = pend_tgt in u+1.
- Accepted request: pc advances one block next cycle. Throughput is one block per cycle when inst_addr_ok is tied high.
- stall and inst_addr_ok do not change the current-cycle inst_req after hold is set.
- Reset asserted mid-handshake: hold and pend are discarded and pc = RESET_PC next cycle. The memory side tolerates request withdrawal on reset.
- exception and br_take in the same cycle: exception wins, branch is discarded.
- A pending exception is not overwritten by a later eret or branch.

## Test plan
- Reset then FETCH_N=1, addr_ok=1: inst_addr sequence bfc00000, bfc00004, bfc00008 on consecutive cycles; pc_adel=0.
- FETCH_N=2, br_target=0x80001004, addr_ok=1: pc=0x80001004, inst_addr=0x80001000, next inst_addr=0x80001008.
- Hold inst_addr_ok=0 for 3 cycles, br_take to 0x80002000 in the 2nd: inst_addr unchanged for all 3 cycles. After the accept, pc=0x80002000.
- While waiting, exception then br_take (0x80003000) in later cycles: after accept pc=0xbfc00380 (branch dropped). Simultaneous exception+eret with adv=1 gives pc=0xbfc00380.
- eret with epc=0x80000002: pc=0x80000002, pc_adel=1, inst_req=0 until exception, then pc=0xbfc00380, inst_req=1.
- Wrap and stall: pc=0xfffffffc, FETCH_N=1, accept gives pc=0. stall=1 with hold=0 gives inst_req=0 and pc frozen. stall=1 with hold=1 keeps inst_req=1 until accepted. reset=1 mid-hold gives pc=RESET_PC and pend_v=0.
